// File: rtl/data_mem_responder_if.sv
// Data-port bundle between the datapath (master) and the data-memory responder (slave).
// Latency: n/a (wires only).
// Backpressure: request is a level held by the master until it sees memReady.
interface data_mem_responder_if;
    logic [31:0] dataMemAddress;
    logic        dataMemRead;
    logic        dataMemWrite;
    logic [31:0] dataWriteValue;
    logic [31:0] dataReadValue;
    logic        memReady;
    logic        memFault;
    logic [15:0] accessCount;

    modport master (
        output dataMemAddress, dataMemRead, dataMemWrite, dataWriteValue,
        input  dataReadValue, memReady, memFault, accessCount
    );

    modport slave (
        input  dataMemAddress, dataMemRead, dataMemWrite, dataWriteValue,
        output dataReadValue, memReady, memFault, accessCount
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-array data memory behind the datapath data port, with a memReady/memFault completion handshake.
// Latency: memReady READ_LATENCY cycles after the sampling edge for reads, 1 cycle for writes and faults.
// Backpressure: none; requests are sampled only in IDLE and the initiator holds its level until memReady.
module data_mem_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h10010000,
    parameter int          DEPTH_WORDS  = 1024,
    parameter int          READ_LATENCY = 2
) (
    input  logic               clock,
    input  logic               resetN,
    data_mem_responder_if.slave bus
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    // Request captured at the sampling edge; everything after that works from this copy.
    typedef struct packed {
        logic             isWrite;
        logic             isFault;
        logic [IDX_W-1:0] index;
        logic [31:0]      writeValue;
    } req_t;

    state_t      stateQ, stateD;
    req_t        reqQ;
    logic [3:0]  counterQ;
    logic [31:0] readValueQ;
    logic [15:0] accessCountQ;

    logic [31:0] dataArray [DEPTH_WORDS];

    logic        request;
    logic        isFault;
    logic [29:0] wordOffset;
    logic        completing;

    // Decode the incoming request: word offset from the base, and every reason to reject it.
    always_comb begin
        request    = bus.dataMemRead | bus.dataMemWrite;
        // Word-granular subtraction; the below-base test guards against wrap-around into range.
        wordOffset = bus.dataMemAddress[31:2] - BASE_ADDR[31:2];
        isFault    = (bus.dataMemRead & bus.dataMemWrite)
                   | (bus.dataMemAddress[1:0] != 2'b00)
                   | (bus.dataMemAddress < BASE_ADDR)
                   | ({2'b00, wordOffset} >= 32'(DEPTH_WORDS));
    end

    assign completing = (stateQ == WAIT) && (counterQ == 4'd0);

    // State register.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state: sample in IDLE, count down in WAIT, DONE lasts one cycle.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE:    if (request) stateD = WAIT;
            WAIT:    if (counterQ == 4'd0) stateD = DONE;
            DONE:    stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    // Outputs: completion pulse decoded from the state register, data and count from registers.
    always_comb begin
        bus.memReady      = (stateQ == DONE);
        bus.memFault      = (stateQ == DONE) && reqQ.isFault;
        bus.dataReadValue = readValueQ;
        bus.accessCount   = accessCountQ;
    end

    // Request latch, latency counter, read data and saturating access counter.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            reqQ         <= '0;
            counterQ     <= 4'd0;
            readValueQ   <= 32'd0;
            accessCountQ <= 16'd0;
        end else begin
            if (stateQ == IDLE && request) begin
                reqQ.isWrite    <= bus.dataMemWrite;
                reqQ.isFault    <= isFault;
                reqQ.index      <= wordOffset[IDX_W-1:0];
                reqQ.writeValue <= bus.dataWriteValue;
                // Writes and faults complete one edge later; reads take the full latency.
                if (isFault || bus.dataMemWrite) begin
                    counterQ <= 4'd0;
                end else begin
                    counterQ <= 4'(READ_LATENCY - 1);
                end
            end else if (stateQ == WAIT && counterQ != 4'd0) begin
                counterQ <= counterQ - 4'd1;
            end

            if (completing && !reqQ.isFault) begin
                if (!reqQ.isWrite) begin
                    readValueQ <= dataArray[reqQ.index];
                end
                if (accessCountQ != 16'hFFFF) begin
                    accessCountQ <= accessCountQ + 16'd1;
                end
            end
        end
    end

    // Array write at completion; reset forces IDLE asynchronously so a pending write is dropped.
    always_ff @(posedge clock) begin
        if (completing && reqQ.isWrite && !reqQ.isFault) begin
            dataArray[reqQ.index] <= reqQ.writeValue;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a queue-based scoreboard.
// The driver pushes the expected completion; the monitor pops it when memReady appears.
module tb_data_mem_responder;

    logic clock = 1'b0;
    logic resetN;

    data_mem_responder_if bus();

    data_mem_responder dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic        fault;
        logic [31:0] readValue;
        logic [15:0] count;
        int          readyCycle;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every completion must match the oldest expectation, including its cycle.
    always @(negedge clock) begin
        if (resetN === 1'b1 && bus.memReady === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready got memReady=1 at cycle %0d want none", cyc);
            end else begin
                monExp = expQ.pop_front();
                check("ready_cycle", 32'(cyc), 32'(monExp.readyCycle));
                check("mem_fault", {31'd0, bus.memFault}, {31'd0, monExp.fault});
                check("read_value", bus.dataReadValue, monExp.readValue);
                check("access_count", {16'd0, bus.accessCount}, {16'd0, monExp.count});
            end
        end
    end

    // Drive one access, register its expected completion, wait for memReady, then drop the request.
    task automatic doAccess(input logic [31:0] addr, input logic rd, input logic wr,
                            input logic [31:0] wdata, input logic expFault,
                            input logic [31:0] expRv, input logic [15:0] expCnt,
                            input int lat, input logic scramble);
        exp_t e;
        bit   seen;
        @(negedge clock);
        bus.dataMemAddress = addr;
        bus.dataMemRead    = rd;
        bus.dataMemWrite   = wr;
        bus.dataWriteValue = wdata;
        e.fault      = expFault;
        e.readValue  = expRv;
        e.count      = expCnt;
        e.readyCycle = cyc + 1 + lat;
        expQ.push_back(e);
        if (scramble) begin
            @(negedge clock);
            bus.dataMemAddress = addr ^ 32'h8;
            bus.dataWriteValue = ~wdata;
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.memReady === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout addr %h got no memReady want memReady within 40 cycles", addr);
        end
        bus.dataMemRead  = 1'b0;
        bus.dataMemWrite = 1'b0;
    endtask

    initial begin
        resetN             = 1'b0;
        bus.dataMemAddress = 32'd0;
        bus.dataMemRead    = 1'b0;
        bus.dataMemWrite   = 1'b0;
        bus.dataWriteValue = 32'd0;
        repeat (2) @(negedge clock);
        check("reset_read_value", bus.dataReadValue, 32'd0);
        check("reset_ready", {31'd0, bus.memReady}, 32'd0);
        check("reset_fault", {31'd0, bus.memFault}, 32'd0);
        check("reset_count", {16'd0, bus.accessCount}, 32'd0);

        dut.dataArray[0] = 32'h11111111;
        dut.dataArray[2] = 32'h00000022;
        dut.dataArray[3] = 32'hDEADBEEF;
        dut.dataArray[5] = 32'h00000055;
        resetN = 1'b1;

        // Basic read with full latency, and the value holds after the request drops.
        doAccess(32'h1001000C, 1, 0, 32'h0, 0, 32'hDEADBEEF, 16'd1, 2, 0);
        repeat (3) @(negedge clock);
        check("read_value_held", bus.dataReadValue, 32'hDEADBEEF);

        // Write then read back.
        doAccess(32'h10010010, 0, 1, 32'h12345678, 0, 32'hDEADBEEF, 16'd2, 1, 0);
        check("array4_written", dut.dataArray[4], 32'h12345678);
        doAccess(32'h10010010, 1, 0, 32'h0, 0, 32'h12345678, 16'd3, 2, 0);

        // Faults: misaligned, below base, one past the end, zero address, and bad writes.
        doAccess(32'h10010002, 1, 0, 32'h0, 1, 32'h12345678, 16'd3, 1, 0);
        doAccess(32'h1000FFFC, 1, 0, 32'h0, 1, 32'h12345678, 16'd3, 1, 0);
        doAccess(32'h10011000, 1, 0, 32'h0, 1, 32'h12345678, 16'd3, 1, 0);
        doAccess(32'h00000000, 1, 0, 32'h0, 1, 32'h12345678, 16'd3, 1, 0);
        doAccess(32'h10011000, 0, 1, 32'hBAD0BAD0, 1, 32'h12345678, 16'd3, 1, 0);
        doAccess(32'h10010012, 0, 1, 32'hBAD0BAD0, 1, 32'h12345678, 16'd3, 1, 0);
        doAccess(32'h10010014, 1, 1, 32'hCAFEF00D, 1, 32'h12345678, 16'd3, 1, 0);
        check("fault_array0_kept", dut.dataArray[0], 32'h11111111);
        check("fault_array4_kept", dut.dataArray[4], 32'h12345678);
        check("fault_array5_kept", dut.dataArray[5], 32'h00000055);

        // Inputs changed while the write waits must be ignored.
        doAccess(32'h10010000, 0, 1, 32'hA5A5A5A5, 0, 32'h12345678, 16'd4, 1, 1);
        check("latched_array0", dut.dataArray[0], 32'hA5A5A5A5);
        check("latched_array2_kept", dut.dataArray[2], 32'h00000022);

        // Reset during WAIT abandons the write.
        dut.dataArray[5] = 32'h00000007;
        @(negedge clock);
        bus.dataMemAddress = 32'h10010014;
        bus.dataWriteValue = 32'h00000001;
        bus.dataMemWrite   = 1'b1;
        @(negedge clock);
        resetN = 1'b0;
        #1;
        check("midreset_read_value", bus.dataReadValue, 32'd0);
        check("midreset_ready", {31'd0, bus.memReady}, 32'd0);
        check("midreset_fault", {31'd0, bus.memFault}, 32'd0);
        check("midreset_count", {16'd0, bus.accessCount}, 32'd0);
        bus.dataMemWrite = 1'b0;
        @(negedge clock);
        @(negedge clock);
        resetN = 1'b1;
        check("midreset_array5_kept", dut.dataArray[5], 32'h00000007);
        doAccess(32'h10010014, 1, 0, 32'h0, 0, 32'h00000007, 16'd1, 2, 0);

        // Saturation of the access counter.
        @(negedge clock);
        dut.accessCountQ = 16'hFFFE;
        doAccess(32'h1001000C, 1, 0, 32'h0, 0, 32'hDEADBEEF, 16'hFFFF, 2, 0);
        doAccess(32'h10010018, 0, 1, 32'h00000066, 0, 32'hDEADBEEF, 16'hFFFF, 1, 0);
        doAccess(32'h10010018, 1, 0, 32'h0, 0, 32'h00000066, 16'hFFFF, 2, 0);

        repeat (5) @(negedge clock);
        check("scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
